stage_mem: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes the EX/MEM values: ALU result, store data, destination register and control bits. It performs loads and stores over a req/ack data-memory handshake, with byte-lane steering and sign/zero extension. It produces the registered MEM/WB values and stalls the execute stage while an access is outstanding.

---
 rtl/stage_mem_pkg.sv | 19 +
 rtl/stage_mem_align.sv | 63 ++++++
 rtl/stage_mem.sv | 178 +++++++++++++++++
 tb/tb_stage_mem.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage of the five-stage pipeline:
// EX/MEM field widths, memory access-size encodings and the FSM states.
package stage_mem_pkg;

   localparam int XLEN   = 32;   // datapath width
   localparam int REG_W  = 5;    // register-file index width
   localparam int SIZE_W = 2;    // access-size field width

   // Access-size encodings carried on ex_mem_size; 2'b11 behaves as a word.
   localparam logic [SIZE_W-1:0] MEM_B = 2'b00;
   localparam logic [SIZE_W-1:0] MEM_H = 2'b01;
   localparam logic [SIZE_W-1:0] MEM_W = 2'b10;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/stage_mem_align.sv
// mem_align: purely combinational byte-lane logic for the memory stage.
//   Store side (from the EX/MEM slot being accepted):
//     acc_lane  - addr[1:0] of the access
//     acc_size  - access size (MEM_B / MEM_H / MEM_W, 2'b11 = word)
//     st_data   - rt value to be stored
//     st_be     - byte enables, bit0 = byte at address offset 0
//     st_wdata  - store data replicated across all lanes
//     misalign  - half with addr[0]=1, or word with addr[1:0]!=0
//   Load side (from the access held in flight):
//     ld_lane, ld_size, ld_signed - lane, size and extension of the load
//     rdata     - word returned by data memory
//     ld_data   - selected lane, sign- or zero-extended to 32 bits
module mem_align
   import stage_mem_pkg::*;
(
   input  logic [1:0]        acc_lane,
   input  logic [SIZE_W-1:0] acc_size,
   input  logic [XLEN-1:0]   st_data,
   output logic [3:0]        st_be,
   output logic [XLEN-1:0]   st_wdata,
   output logic              misalign,
   input  logic [1:0]        ld_lane,
   input  logic [SIZE_W-1:0] ld_size,
   input  logic              ld_signed,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      misalign = 1'b0;
      case (acc_size)
         MEM_B: begin
            st_be    = 4'b0001 << acc_lane;
            st_wdata = {4{st_data[7:0]}};
         end
         MEM_H: begin
            st_be    = acc_lane[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
            misalign = acc_lane[0];
         end
         default: begin
            misalign = |acc_lane;
         end
      endcase
   end

   // Little-endian: lane k holds bits [8k+7:8k]; halves are picked by lane[1].
   always_comb begin
      ld_byte = rdata[8*ld_lane +: 8];
      ld_half = rdata[16*ld_lane[1] +: 16];
      case (ld_size)
         MEM_B:   ld_data = {{24{ld_byte[7] & ld_signed}}, ld_byte};
         MEM_H:   ld_data = {{16{ld_half[15] & ld_signed}}, ld_half};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access stage. Accepts the EX/MEM slot, performs loads and
// stores over a req/ack data-memory handshake and produces the registered
// MEM/WB values. Execute is stalled (ex_ready low) while an access is open.
//   ex_*       - EX/MEM slot from execute; ex_ready is the stall back to EX
//   dmem_*     - data-memory request (held stable until dmem_ack)
//   wb_*       - MEM/WB slot, wb_valid pulses once per instruction
//   mem_misalign / mem_bus_err - one-cycle exception pulses
// Optional build macro MEM_TIMEOUT_EN: bounds the ack wait to TIMEOUT_CYCLES
// cycles and reports expiry on mem_bus_err; otherwise mem_bus_err is 0.
module stage_mem
   import stage_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [XLEN-1:0]   ex_alu_result,
   input  logic [XLEN-1:0]   ex_store_data,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [SIZE_W-1:0] ex_mem_size,
   input  logic              ex_mem_signed,
   input  logic              ex_reg_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic [REG_W-1:0]  wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_reg_write,
   output logic              mem_misalign,
   output logic              mem_bus_err
);

   state_t            state;
   logic [3:0]        st_be;
   logic [XLEN-1:0]   st_wdata;
   logic              misalign;
   logic [XLEN-1:0]   ld_data;

   // In-flight access context, captured on acceptance.
   logic [1:0]        lane_p1;
   logic [SIZE_W-1:0] size_p1;
   logic              signed_p1;
   logic              store_p1;
   logic [REG_W-1:0]  rd_p1;
   logic              reg_write_p1;
   logic [XLEN-1:0]   result_p1;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt;
   logic             bus_err_q;
   assign mem_bus_err = bus_err_q;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
   assign mem_bus_err = 1'b0;
`endif

   assign ex_ready = (state == ST_IDLE);

   mem_align u_align (
      .acc_lane  (ex_alu_result[1:0]),
      .acc_size  (ex_mem_size),
      .st_data   (ex_store_data),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .misalign  (misalign),
      .ld_lane   (lane_p1),
      .ld_size   (size_p1),
      .ld_signed (signed_p1),
      .rdata     (dmem_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_be      <= '0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_reg_write <= 1'b0;
         mem_misalign <= 1'b0;
         lane_p1      <= '0;
         size_p1      <= '0;
         signed_p1    <= 1'b0;
         store_p1     <= 1'b0;
         rd_p1        <= '0;
         reg_write_p1 <= 1'b0;
         result_p1    <= '0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt      <= '0;
         bus_err_q    <= 1'b0;
`endif
      end else begin
         wb_valid     <= 1'b0;
         mem_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         bus_err_q    <= 1'b0;
`endif
         case (state)
            // ---- EX/MEM -> MEM: accept the slot ----
            ST_IDLE: begin
               if (ex_valid) begin
                  if (!(ex_mem_read || ex_mem_write)) begin
                     wb_valid     <= 1'b1;
                     wb_rd        <= ex_rd;
                     wb_data      <= ex_alu_result;
                     wb_reg_write <= ex_reg_write;
                  end else if (misalign) begin
                     // Retire without touching memory and suppress write-back.
                     wb_valid     <= 1'b1;
                     wb_rd        <= ex_rd;
                     wb_data      <= ex_alu_result;
                     wb_reg_write <= 1'b0;
                     mem_misalign <= 1'b1;
                  end else begin
                     state        <= ST_ACCESS;
                     dmem_req     <= 1'b1;
                     dmem_we      <= ex_mem_write;
                     dmem_addr    <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                     dmem_be      <= ex_mem_write ? st_be : 4'b1111;
                     dmem_wdata   <= st_wdata;
                     lane_p1      <= ex_alu_result[1:0];
                     size_p1      <= ex_mem_size;
                     signed_p1    <= ex_mem_signed;
                     store_p1     <= ex_mem_write;
                     rd_p1        <= ex_rd;
                     reg_write_p1 <= ex_reg_write;
                     result_p1    <= ex_alu_result;
`ifdef MEM_TIMEOUT_EN
                     tmo_cnt      <= '0;
`endif
                  end
               end
            end
            // ---- MEM -> MEM/WB: wait for the memory to complete ----
            ST_ACCESS: begin
               if (dmem_ack) begin
                  state        <= ST_IDLE;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_rd        <= rd_p1;
                  wb_data      <= store_p1 ? result_p1 : ld_data;
                  wb_reg_write <= reg_write_p1 & ~store_p1;
`ifdef MEM_TIMEOUT_EN
               end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state        <= ST_IDLE;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_rd        <= rd_p1;
                  wb_data      <= result_p1;
                  wb_reg_write <= 1'b0;
                  bus_err_q    <= 1'b1;
               end else begin
                  tmo_cnt      <= tmo_cnt + 1'b1;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_mem_size;
   logic        ex_mem_signed;
   logic        ex_reg_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_reg_write;
   logic        mem_misalign;
   logic        mem_bus_err;

   always #5 clk = ~clk;

   stage_mem dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_mem_size   (ex_mem_size),
      .ex_mem_signed (ex_mem_signed),
      .ex_reg_write  (ex_reg_write),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_be       (dmem_be),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .wb_reg_write  (wb_reg_write),
      .mem_misalign  (mem_misalign),
      .mem_bus_err   (mem_bus_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // Model state: expected MEM/WB retirements and the request currently expected on the bus.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        rw;
      logic        mis;
      logic        chkd;
   } wb_t;

   wb_t         expq[$];
   logic        chk_en     = 1'b0;
   logic        exp_req_v  = 1'b0;
   logic [31:0] exp_addr   = '0;
   logic [3:0]  exp_be     = '0;
   logic [31:0] exp_wdata  = '0;
   logic        exp_we     = 1'b0;
   int          ready_low  = 0;
   int          req_cycles = 0;
   logic [31:0] last_addr  = '0;
   logic [31:0] last_wdata = '0;
   logic [3:0]  last_be    = '0;
   logic        last_we    = 1'b0;

   // Compare process: every cycle once out of the initial reset.
   always @(negedge clk) begin
      if (chk_en) begin
         if (!ex_ready) ready_low++;
         chk("mem_bus_err", 32'(mem_bus_err), 32'd0);
         if (wb_valid) begin
            if (expq.size() == 0) begin
               chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
               wb_t e;
               e = expq.pop_front();
               chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               if (e.chkd) chk("wb_data", wb_data, e.data);
               chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
               chk("mem_misalign", 32'(mem_misalign), 32'(e.mis));
            end
         end else begin
            chk("misalign_idle", 32'(mem_misalign), 32'd0);
         end
         chk("dmem_req", 32'(dmem_req), 32'(exp_req_v));
         if (dmem_req) begin
            req_cycles++;
            last_addr  = dmem_addr;
            last_be    = dmem_be;
            last_wdata = dmem_wdata;
            last_we    = dmem_we;
            if (exp_req_v) begin
               chk("dmem_addr", dmem_addr, exp_addr);
               chk("dmem_be", 32'(dmem_be), 32'(exp_be));
               chk("dmem_we", 32'(dmem_we), 32'(exp_we));
               if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
         end
      end
   end

   // Issue one instruction; d = ACCESS cycles until ack (aligned memory ops only).
   task automatic do_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rdn, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic rw, input int d, input logic [31:0] rdata);
      int          nb;
      int          k;
      logic        mem;
      logic        mis;
      logic [63:0] mask;
      logic [63:0] val;
      wb_t         e;
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      k    = int'(alu % 4);
      mem  = rdn | wr;
      mis  = mem && ((alu % nb) != 0);
      e.rd = rd; e.mis = mis; e.data = '0; e.rw = 1'b0; e.chkd = 1'b0;
      if (!mem) begin
         e.data = alu; e.rw = rw; e.chkd = 1'b1;
      end else if (!mis && !wr) begin
         mask = (64'd1 << (8 * nb)) - 64'd1;
         val  = (64'(rdata) >> (8 * k)) & mask;
         if (sgn && nb < 4 && val[8*nb-1]) val = val | ~mask;
         e.data = val[31:0]; e.rw = rw; e.chkd = 1'b1;
      end

      @(posedge clk); #1;
      chk("ex_ready_idle", 32'(ex_ready), 32'd1);
      ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
      ex_mem_read = rdn; ex_mem_write = wr; ex_mem_size = sz;
      ex_mem_signed = sgn; ex_reg_write = rw; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      expq.push_back(e);
      if (mem && !mis) begin
         exp_addr  = alu & ~32'd3;
         exp_we    = wr;
         exp_be    = wr ? 4'(((1 << nb) - 1) << k) : 4'hF;
         exp_wdata = (nb == 1) ? sd[7:0] * 32'h01010101 :
                     (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
         exp_req_v = 1'b1;
         for (int i = 1; i < d; i++) begin
            @(posedge clk); #1;
         end
         dmem_ack = 1'b1; dmem_rdata = rdata;
         @(posedge clk); #1;
         dmem_ack = 1'b0; dmem_rdata = 32'h5A5A5A5A;
         exp_req_v = 1'b0;
      end
   endtask

   initial begin
      int r0;
      int q0;
      rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = '0; ex_mem_signed = 1'b0;
      ex_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ex_ready", 32'(ex_ready), 32'd1);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_dmem_we", 32'(dmem_we), 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_be", 32'(dmem_be), 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
      chk("rst_misalign", 32'(mem_misalign), 32'd0);
      chk("rst_bus_err", 32'(mem_bus_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Non-memory op, latency 1, no stall.
      r0 = ready_low;
      do_op(32'h7, 32'h0, 5'd5, 0, 0, 2'd2, 0, 1, 0, 32'h0);
      @(negedge clk);
      chk("alu_wb_valid", 32'(wb_valid), 32'd1);
      chk("alu_wb_rd", 32'(wb_rd), 32'd5);
      chk("alu_wb_data", wb_data, 32'h7);
      chk("alu_wb_reg_write", 32'(wb_reg_write), 32'd1);
      chk("alu_no_stall", 32'(ready_low - r0), 32'd0);

      // lw 0x100, ack after 3 ACCESS cycles.
      r0 = ready_low;
      do_op(32'h100, 32'h0, 5'd9, 1, 0, 2'd2, 0, 1, 3, 32'hDEADBEEF);
      @(negedge clk);
      chk("lw_addr", last_addr, 32'h100);
      chk("lw_be", 32'(last_be), 32'hF);
      chk("lw_we", 32'(last_we), 32'd0);
      chk("lw_wb_data", wb_data, 32'hDEADBEEF);
      chk("lw_stall_cycles", 32'(ready_low - r0), 32'd3);

      // lb / lbu at 0x103.
      do_op(32'h103, 32'h0, 5'd10, 1, 0, 2'd0, 1, 1, 1, 32'h80123456);
      @(negedge clk);
      chk("lb_wb_data", wb_data, 32'hFFFFFF80);
      do_op(32'h103, 32'h0, 5'd11, 1, 0, 2'd0, 0, 1, 1, 32'h80123456);
      @(negedge clk);
      chk("lbu_wb_data", wb_data, 32'h00000080);

      // lh / lhu.
      do_op(32'h42, 32'h0, 5'd12, 1, 0, 2'd1, 1, 1, 2, 32'h80017FFF);
      @(negedge clk);
      chk("lh_wb_data", wb_data, 32'hFFFF8001);
      do_op(32'h40, 32'h0, 5'd13, 1, 0, 2'd1, 0, 1, 1, 32'h80017FFF);
      @(negedge clk);
      chk("lhu_wb_data", wb_data, 32'h00007FFF);

      // sh 0x202.
      do_op(32'h202, 32'h1234ABCD, 5'd14, 0, 1, 2'd1, 0, 1, 2, 32'h0);
      @(negedge clk);
      chk("sh_be", 32'(last_be), 32'hC);
      chk("sh_wdata", last_wdata, 32'hABCDABCD);
      chk("sh_we", 32'(last_we), 32'd1);
      chk("sh_wb_reg_write", 32'(wb_reg_write), 32'd0);

      // sb 0x001, sw with size 11 at 0x010.
      do_op(32'h001, 32'h000000CD, 5'd15, 0, 1, 2'd0, 0, 1, 1, 32'h0);
      @(negedge clk);
      chk("sb_be", 32'(last_be), 32'h2);
      chk("sb_wdata", last_wdata, 32'hCDCDCDCD);
      do_op(32'h010, 32'hCAFEF00D, 5'd16, 0, 1, 2'd3, 0, 0, 1, 32'h0);
      @(negedge clk);
      chk("sw11_be", 32'(last_be), 32'hF);
      chk("sw11_wdata", last_wdata, 32'hCAFEF00D);

      // Misaligned lw 0x101 and sh 0x201: no request.
      q0 = req_cycles;
      do_op(32'h101, 32'h0, 5'd17, 1, 0, 2'd2, 0, 1, 0, 32'h0);
      @(negedge clk);
      chk("mis_lw_pulse", 32'(mem_misalign), 32'd1);
      chk("mis_lw_wb_valid", 32'(wb_valid), 32'd1);
      chk("mis_lw_reg_write", 32'(wb_reg_write), 32'd0);
      do_op(32'h201, 32'h1111, 5'd18, 0, 1, 2'd1, 0, 1, 0, 32'h0);
      @(negedge clk);
      chk("mis_sh_pulse", 32'(mem_misalign), 32'd1);
      chk("mis_no_req", 32'(req_cycles - q0), 32'd0);

      // Reset during the second ACCESS cycle, then a late ack.
      @(posedge clk); #1;
      ex_alu_result = 32'h100; ex_rd = 5'd20; ex_mem_read = 1'b1; ex_mem_size = 2'd2;
      ex_reg_write = 1'b1; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_mem_read = 1'b0;
      exp_addr = 32'h100; exp_be = 4'hF; exp_we = 1'b0; exp_req_v = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; exp_req_v = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_ex_ready", 32'(ex_ready), 32'd1);
         chk("abort_dmem_req", 32'(dmem_req), 32'd0);
         chk("abort_wb_valid", 32'(wb_valid), 32'd0);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;

      // Recovery after the abort.
      do_op(32'h33, 32'h0, 5'd3, 0, 0, 2'd0, 0, 1, 0, 32'h0);
      @(negedge clk);
      chk("recover_wb_data", wb_data, 32'h33);
      repeat (2) @(negedge clk);
      chk("wb_missing", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
